udp_seq_bank: RTL and testbench
===============================

// Module: udp_seq_bank
// PURPOSE
//   Parametrised bank of NCH programmable 2-input primitives, each a 4-entry truth table.
//   Each channel runs in one of four modes: registered combinational, edge-sensitive,
//   level-sensitive or toggle. This adds sequential-primitive behaviour that fixed
//   combinational primitives lack.
//   Sits behind the cosim spec wrapper and is driven from the packed stimulus vector.
// PARAMETERS
//   NCH        8        number of channels (>=1)
//   DEFAULT_TT 4'b1000  reset truth table, indexed tt[{a,b}]; default = AND
//   CHW        $clog2(NCH) (min 1)  width of cfg_ch; derived, do not override
// PORTS
//   clk        in   1        single clock, all state on posedge
//   rst_n      in   1        asynchronous, active-low reset
//   clr        in   1        synchronous clear of channel state (config kept)
//   in_valid   in   1        evaluate all channels this cycle
//   in_a       in   NCH      per-channel input a (clock/gate role in seq modes)
//   in_b       in   NCH      per-channel input b (data role in seq modes)
//   out_valid  out  1        out_q updated from an evaluation
//   out_q      out  NCH      registered per-channel outputs
//   cfg_valid  in   1        config write request
//   cfg_ready  out  1        config write can be accepted
//   cfg_ch     in   CHW      channel to configure
//   cfg_mode   in   2        new mode (udp_seq_pkg::mode_e)
//   cfg_tt     in   4        new truth table
// BEHAVIOUR
//   Reset (rst_n=0, async):
//     - out_q=0, out_valid=0, cfg_ready=0.
//     - every channel: a_prev=0, mode=MODE_COMB, tt=DEFAULT_TT.
//   cfg_ready is a flop. It goes 1 on the first clk edge after reset release and stays 1.
//   Config handshake: a write is accepted when cfg_valid && cfg_ready.
//     - It takes effect at that edge. Evaluation in the same cycle uses the OLD mode/tt.
//     - A write with cfg_ch >= NCH is accepted and dropped.
//     - A mode change keeps q and a_prev.
//   Evaluation (in_valid=1, clr=0): all channels update at the edge. out_valid<=1.
//   For each channel, let t = tt[{a,b}] and rise = a & ~a_prev:
//     - MODE_COMB   (0): q <= t
//     - MODE_EDGE   (1): q <= rise ? b : q        (D-flop primitive, a = clock)
//     - MODE_LATCH  (2): q <= a ? b : q           (transparent-high latch)
//     - MODE_TOGGLE (3): q <= (rise & t) ? ~q : q (tt gates the toggle)
//     - In all modes, a_prev <= a.
//   No in_valid: out_valid<=0. q and a_prev hold. Latency in->out_q is 1 cycle.
//   clr=1: q<=0, a_prev<=0, out_valid<=0. clr wins over in_valid.
//     clr does not block a config write in the same cycle.
//   a_prev is cleared by reset and by clr. The first valid sample with a=1 after either is an edge.
// STRUCTURE
//   udp_seq_pkg holds:
//     - typedef enum logic [1:0] mode_e {MODE_COMB, MODE_EDGE, MODE_LATCH, MODE_TOGGLE}
//     - tt index helper function
//   Sub-module udp_seq_cell is one channel holding mode, tt, a_prev and q.
//     - It takes a write-enable, the eval strobe and clr.
//     - The top instantiates NCH cells in a generate loop. It owns out_valid, cfg_ready
//       and the cfg_ch decode.
// TESTING
//   1. Reset, NCH=8: drive a=8'hF0, b=8'hCC, in_valid for 1 cycle -> out_q=8'hC0, out_valid=1
//      for 1 cycle.
//   2. Write tt=4'b0110 (XOR) to every channel, then a=8'hF0, b=8'hCC -> out_q=8'h3C. A write
//      to ch0 in the same cycle as eval still gives the old result.
//   3. ch2 in MODE_EDGE:
//        - (a,b) = (0,1), (1,1), (1,0), (0,0), (1,0) -> q2 = 0,1,1,1,0.
//        - Gaps without in_valid leave q2 unchanged.
//   4. ch3 in MODE_LATCH:
//        - (a,b) = (1,1), (1,0), (0,1), (1,1) -> q3 = 1,0,0,1.
//   5. ch4 in MODE_TOGGLE with tt=4'b1111:
//        - a pattern 0,1,0,1,1 -> q4 = 0,1,1,0,0.
//        - clr -> q4=0, out_valid=0. The next a=1 toggles q4 to 1.
//   6. Assert rst_n mid-run -> out_q=0 and cfg_ready=0 immediately, config back to AND.
//      Write with cfg_ch=8 (NCH=8) -> no channel changes.

Source files
------------

// File: rtl/udp_seq_pkg.sv
// udp_seq_pkg: shared types and helpers
// for the programmable primitive bank.
package udp_seq_pkg;

  typedef enum logic [1:0] {
    MODE_COMB   = 2'd0,
    MODE_EDGE   = 2'd1,
    MODE_LATCH  = 2'd2,
    MODE_TOGGLE = 2'd3
  } mode_e;

  function automatic logic tt_lookup(
    input logic [3:0] tt,
    input logic       a,
    input logic       b
  );
    return tt[{a, b}];
  endfunction

endpackage

// File: rtl/udp_seq_cell.sv
// udp_seq_cell: one channel of the bank,
// truth table plus mode-selected next-state.
module udp_seq_cell
  import udp_seq_pkg::*;
#(
  parameter logic [3:0] DEFAULT_TT = 4'b1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       eval,
  input  logic       we,
  input  logic [1:0] wmode,
  input  logic [3:0] wtt,
  input  logic       a,
  input  logic       b,
  output logic       q
);

  mode_e      mode;
  logic [3:0] tt;
  logic       a_prev;
  logic       t;
  logic       rise;
  logic       nq;

  assign t    = tt_lookup(tt, a, b);
  assign rise = a & ~a_prev;

  // next q for the current mode
  always_comb begin
    nq = q;
    unique case (1'b1)
      (mode == MODE_COMB):   nq = t;
      (mode == MODE_EDGE):   nq = rise ? b : q;
      (mode == MODE_LATCH):  nq = a ? b : q;
      (mode == MODE_TOGGLE): nq = (rise & t) ? ~q : q;
      default:               nq = q;
    endcase
  end

  // config: written regardless of clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode <= MODE_COMB;
      tt   <= DEFAULT_TT;
    end else if (we) begin
      mode <= mode_e'(wmode);
      tt   <= wtt;
    end
  end

  // channel state: clr beats eval
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q      <= 1'b0;
      a_prev <= 1'b0;
    end else if (clr) begin
      q      <= 1'b0;
      a_prev <= 1'b0;
    end else if (eval) begin
      q      <= nq;
      a_prev <= a;
    end
  end

endmodule

// File: rtl/udp_seq_bank.sv
// udp_seq_bank: NCH programmable 2-input
// primitives with a config write port.
module udp_seq_bank
  import udp_seq_pkg::*;
#(
  parameter int         NCH        = 8,
  parameter logic [3:0] DEFAULT_TT = 4'b1000,
  localparam int        CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           in_valid,
  input  logic [NCH-1:0] in_a,
  input  logic [NCH-1:0] in_b,
  output logic           out_valid,
  output logic [NCH-1:0] out_q,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [1:0]     cfg_mode,
  input  logic [3:0]     cfg_tt
);

  logic           acc;
  logic [NCH-1:0] we;

  assign acc = cfg_valid & cfg_ready;

  // ready rises one edge after reset; valid tracks evals
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ready <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      cfg_ready <= 1'b1;
      out_valid <= in_valid & ~clr;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam logic [CHW-1:0] IDX = CHW'(i);

    assign we[i] = acc & (cfg_ch == IDX);

    udp_seq_cell #(
      .DEFAULT_TT(DEFAULT_TT)
    ) u_cell (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clr),
      .eval (in_valid),
      .we   (we[i]),
      .wmode(cfg_mode),
      .wtt  (cfg_tt),
      .a    (in_a[i]),
      .b    (in_b[i]),
      .q    (out_q[i])
    );
  end

endmodule

// File: tb/tb_udp_seq_bank.sv
// tb_udp_seq_bank: directed and random checks
// against a truth-table level channel model.
module tb_udp_seq_bank;
  import udp_seq_pkg::*;

  localparam int NCH = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           clr;
  logic           in_valid;
  logic [NCH-1:0] in_a;
  logic [NCH-1:0] in_b;
  logic           out_valid;
  logic [NCH-1:0] out_q;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [2:0]     cfg_ch;
  logic [1:0]     cfg_mode;
  logic [3:0]     cfg_tt;

  logic       clr6;
  logic       iv6;
  logic [5:0] a6;
  logic [5:0] b6;
  logic       ov6;
  logic [5:0] q6;
  logic       cv6;
  logic       rdy6;
  logic [2:0] ch6;
  logic [1:0] mode6;
  logic [3:0] tt6;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] m_mode [NCH];
  logic [3:0] m_tt   [NCH];
  logic       m_q    [NCH];
  logic       m_ap   [NCH];
  logic       m_ov;
  logic       m_rdy;

  always #5 clk = ~clk;

  udp_seq_bank #(.NCH(NCH), .DEFAULT_TT(4'b1000)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (in_valid),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_q    (out_q),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_mode (cfg_mode),
    .cfg_tt   (cfg_tt)
  );

  udp_seq_bank #(.NCH(6), .DEFAULT_TT(4'b1000)) u_dut6 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr6),
    .in_valid (iv6),
    .in_a     (a6),
    .in_b     (b6),
    .out_valid(ov6),
    .out_q    (q6),
    .cfg_valid(cv6),
    .cfg_ready(rdy6),
    .cfg_ch   (ch6),
    .cfg_mode (mode6),
    .cfg_tt   (tt6)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_mode[c] = 2'd0;
      m_tt[c]   = 4'b1000;
      m_q[c]    = 1'b0;
      m_ap[c]   = 1'b0;
    end
    m_ov  = 1'b0;
    m_rdy = 1'b0;
  endtask

  function automatic logic [NCH-1:0] exp_q();
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++) v[c] = m_q[c];
    return v;
  endfunction

  task automatic model_edge();
    logic aa, bb, t, rise;
    for (int c = 0; c < NCH; c++) begin
      if (clr) begin
        m_q[c]  = 1'b0;
        m_ap[c] = 1'b0;
      end else if (in_valid) begin
        aa   = in_a[c];
        bb   = in_b[c];
        t    = m_tt[c][{aa, bb}];
        rise = aa && !m_ap[c];
        case (m_mode[c])
          2'd0: m_q[c] = t;
          2'd1: if (rise) m_q[c] = bb;
          2'd2: if (aa) m_q[c] = bb;
          default: if (rise && t) m_q[c] = !m_q[c];
        endcase
        m_ap[c] = aa;
      end
    end
    if (cfg_valid && m_rdy && int'(cfg_ch) < NCH) begin
      m_mode[cfg_ch] = cfg_mode;
      m_tt[cfg_ch]   = cfg_tt;
    end
    m_ov  = in_valid && !clr;
    m_rdy = 1'b1;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("q", 32'(out_q), 32'(exp_q()));
    chk("ov", 32'(out_valid), 32'(m_ov));
    chk("rdy", 32'(cfg_ready), 32'(m_rdy));
  endtask

  task automatic ev(input logic v, input logic [7:0] a,
                    input logic [7:0] b);
    in_valid = v;
    in_a     = a;
    in_b     = b;
  endtask

  task automatic wr(input logic v, input logic [2:0] ch,
                    input logic [1:0] m, input logic [3:0] t);
    cfg_valid = v;
    cfg_ch    = ch;
    cfg_mode  = m;
    cfg_tt    = t;
  endtask

  logic [4:0] sa, sb, sq;
  logic [7:0] ra, rb;

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    ev(0, 8'h00, 8'h00);
    wr(0, 3'd0, 2'd0, 4'h0);
    clr6 = 1'b0; iv6 = 1'b0; a6 = '0; b6 = '0;
    cv6 = 1'b0; ch6 = '0; mode6 = '0; tt6 = '0;
    model_reset();
    #12;
    chk("rst_q", 32'(out_q), 32'h0);
    chk("rst_ov", 32'(out_valid), 32'h0);
    chk("rst_rdy", 32'(cfg_ready), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // default AND
    ev(1, 8'hF0, 8'hCC);
    step();
    chk("and_q", 32'(out_q), 32'hC0);
    chk("and_ov", 32'(out_valid), 32'h1);
    ev(0, 8'h0F, 8'h33);
    step();
    chk("hold_q", 32'(out_q), 32'hC0);
    chk("hold_ov", 32'(out_valid), 32'h0);

    // XOR everywhere
    for (int c = 0; c < NCH; c++) begin
      wr(1, 3'(c), MODE_COMB, 4'b0110);
      step();
    end
    wr(0, 3'd0, 2'd0, 4'h0);
    ev(1, 8'hF0, 8'hCC);
    step();
    chk("xor_q", 32'(out_q), 32'h3C);
    wr(1, 3'd0, MODE_COMB, 4'b1000);
    ev(1, 8'hFF, 8'h00);
    step();
    chk("wr_same_cyc", 32'(out_q), 32'hFF);
    wr(0, 3'd0, 2'd0, 4'h0);
    step();
    chk("wr_after", 32'(out_q), 32'hFE);

    // edge mode on ch2
    wr(1, 3'd2, MODE_EDGE, 4'b0110);
    ev(0, 8'h00, 8'h00);
    step();
    wr(0, 3'd0, 2'd0, 4'h0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    sa = 5'b10110; sb = 5'b00011; sq = 5'b01110;
    for (int i = 0; i < 5; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      ra[2] = sa[i]; rb[2] = sb[i];
      ev(1, ra, rb);
      step();
      chk("edge_q2", 32'(out_q[2]), 32'(sq[i]));
      ev(0, 8'($urandom), 8'($urandom));
      step();
      chk("edge_gap", 32'(out_q[2]), 32'(sq[i]));
    end

    // latch mode on ch3
    wr(1, 3'd3, MODE_LATCH, 4'b0000);
    ev(0, 8'h00, 8'h00);
    step();
    wr(0, 3'd0, 2'd0, 4'h0);
    sa = 5'b01011; sb = 5'b01101; sq = 5'b01001;
    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      ra[3] = sa[i]; rb[3] = sb[i];
      ev(1, ra, rb);
      step();
      chk("latch_q3", 32'(out_q[3]), 32'(sq[i]));
    end

    // toggle mode on ch4
    wr(1, 3'd4, MODE_TOGGLE, 4'b1111);
    ev(0, 8'h00, 8'h00);
    step();
    wr(0, 3'd0, 2'd0, 4'h0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    sa = 5'b11010; sq = 5'b00110;
    for (int i = 0; i < 5; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      ra[4] = sa[i];
      ev(1, ra, rb);
      step();
      chk("tog_q4", 32'(out_q[4]), 32'(sq[i]));
    end
    clr = 1'b1;
    ev(1, 8'hFF, 8'hFF);
    wr(1, 3'd5, MODE_LATCH, 4'b0001);
    step();
    chk("clr_q4", 32'(out_q[4]), 32'h0);
    chk("clr_ov", 32'(out_valid), 32'h0);
    clr = 1'b0;
    wr(0, 3'd0, 2'd0, 4'h0);
    ra = 8'($urandom); ra[4] = 1'b1;
    ev(1, ra, 8'($urandom));
    step();
    chk("clr_tog_q4", 32'(out_q[4]), 32'h1);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      ev($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom));
      clr = ($urandom_range(0, 15) == 0);
      wr($urandom_range(0, 5) == 0, 3'($urandom), 2'($urandom),
         4'($urandom));
      step();
    end

    // async reset mid-run
    clr = 1'b0;
    ev(0, 8'h00, 8'h00);
    wr(0, 3'd0, 2'd0, 4'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_q", 32'(out_q), 32'h0);
    chk("mrst_rdy", 32'(cfg_ready), 32'h0);
    chk("mrst_ov", 32'(out_valid), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wr(1, 3'd1, MODE_COMB, 4'b0110);
    step();
    wr(0, 3'd0, 2'd0, 4'h0);
    ev(1, 8'hFF, 8'h0F);
    step();
    chk("mrst_and", 32'(out_q), 32'h0F);
    ev(0, 8'h00, 8'h00);

    // out-of-range channel on a 6-wide bank
    chk("rdy6", 32'(rdy6), 32'h1);
    cv6 = 1'b1; ch6 = 3'd6; mode6 = MODE_TOGGLE; tt6 = 4'b0000;
    @(posedge clk);
    #1;
    ch6 = 3'd7; mode6 = MODE_LATCH;
    @(posedge clk);
    #1;
    cv6 = 1'b0;
    iv6 = 1'b1; a6 = 6'h3F; b6 = 6'h3F;
    @(posedge clk);
    #1;
    chk("oor_q6", 32'(q6), 32'h3F);
    iv6 = 1'b0;
    cv6 = 1'b1; ch6 = 3'd5; mode6 = MODE_COMB; tt6 = 4'b0000;
    @(posedge clk);
    #1;
    cv6 = 1'b0;
    iv6 = 1'b1;
    @(posedge clk);
    #1;
    chk("inr_q6", 32'(q6), 32'h1F);
    iv6 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
